ex_muldiv_ctrl: RTL

Sequencer for the RV32M multiply/divide resource in the EX stage. It accepts an M-extension instruction held in ID/EX and runs an iterative shift-add multiplier or a restoring divider, one bit per cycle. While the operation runs it raises a stall request to the hazard unit, which holds PC, IF/ID and ID/EX and bubbles EX/MEM. It also resolves the RISC-V divide special cases without iterating.

---
 rtl/ex_muldiv_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: RV32M multiply/divide sequencer for the EX stage.
// Runs a shift-add multiplier or a restoring divider one bit per cycle on
// operand magnitudes, then applies the sign fix-up. It raises a stall to the
// hazard unit while iterating. Divide-by-zero and signed overflow resolve at
// accept without iterating.
//
// Optional build macro: MULDIV_FAST_MUL_EN
//   defined   - MUL* ops complete combinationally in the accept cycle (no stall)
//   undefined - MUL* ops iterate like divides
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ID_EX_mdValid   EX-stage instruction is an M-extension op
//   ID_EX_mdOp      funct3 of the M op
//   rs1Val, rs2Val  forwarded operands, sampled only in the accept cycle
//   mdFlush         kill the in-flight op
//   mdStall         stall request to the hazard unit (combinational)
//   mdDone          mdResult valid, instruction advances this cycle
//   mdResult        rd write value
module ex_muldiv_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ID_EX_mdValid,
  input  logic [2:0]      ID_EX_mdOp,
  input  logic [XLEN-1:0] rs1Val,
  input  logic [XLEN-1:0] rs2Val,
  input  logic            mdFlush,
  output logic            mdStall,
  output logic            mdDone,
  output logic [XLEN-1:0] mdResult
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned ACC_W = 2 * XLEN;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;      // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]   opd_q, opd_d;      // multiplicand or divisor magnitude
  logic              neg_q, neg_d;      // negate final result
  logic              sel_q, sel_d;      // mul: take high half; div: take remainder
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode at accept
  logic            accept_c;
  logic            a_signed_c, b_signed_c, a_neg_c, b_neg_c;
  logic [XLEN-1:0] a_mag_c, b_mag_c;
  logic            div_zero_c, div_ovf_c;
  logic [XLEN-1:0] special_res_c;
  logic            fast_hit_c;

  always_comb begin
    accept_c   = (state_q == ST_IDLE) && ID_EX_mdValid && !mdFlush;
    a_signed_c = ID_EX_mdOp[2] ? !ID_EX_mdOp[0]
                               : (ID_EX_mdOp[1:0] == 2'b01) || (ID_EX_mdOp[1:0] == 2'b10);
    b_signed_c = ID_EX_mdOp[2] ? !ID_EX_mdOp[0] : (ID_EX_mdOp[1:0] == 2'b01);
    a_neg_c    = a_signed_c && rs1Val[XLEN-1];
    b_neg_c    = b_signed_c && rs2Val[XLEN-1];
    a_mag_c    = a_neg_c ? XLEN'(-rs1Val) : rs1Val;
    b_mag_c    = b_neg_c ? XLEN'(-rs2Val) : rs2Val;
    div_zero_c = (rs2Val == '0);
    div_ovf_c  = !ID_EX_mdOp[0] && (rs1Val == INT_MIN) && (rs2Val == '1);
    // x/0: quotient all-ones, remainder = dividend; MIN/-1: quotient MIN, remainder 0
    if (div_zero_c) special_res_c = ID_EX_mdOp[1] ? rs1Val : '1;
    else            special_res_c = ID_EX_mdOp[1] ? '0 : INT_MIN;
  end

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle product on sign-extended operands; truncation keeps it exact
  logic [ACC_W-1:0] fast_a_c, fast_b_c, fast_prod_c;
  logic [XLEN-1:0]  fast_res_c;

  always_comb begin
    fast_a_c    = {{XLEN{a_neg_c}}, rs1Val};
    fast_b_c    = {{XLEN{b_neg_c}}, rs2Val};
    fast_prod_c = fast_a_c * fast_b_c;
    fast_res_c  = (ID_EX_mdOp[1:0] == 2'b00) ? fast_prod_c[XLEN-1:0] : fast_prod_c[ACC_W-1:XLEN];
    fast_hit_c  = !rst && accept_c && !ID_EX_mdOp[2];
  end
`else
  // One shift-add step: conditionally add multiplicand into the high half, shift right
  logic [XLEN:0]    mul_sum_c;
  logic [ACC_W-1:0] mul_next_c, mul_fix_c;
  logic [XLEN-1:0]  mul_res_c;

  always_comb begin
    fast_hit_c = 1'b0;
    mul_sum_c  = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : {(XLEN+1){1'b0}});
    mul_next_c = {mul_sum_c, acc_q[XLEN-1:1]};
    mul_fix_c  = neg_q ? ACC_W'(-mul_next_c) : mul_next_c;
    mul_res_c  = sel_q ? mul_fix_c[ACC_W-1:XLEN] : mul_fix_c[XLEN-1:0];
  end
`endif

  // One restoring-divide step: shift in the next dividend bit, trial-subtract
  logic [XLEN:0]    div_shift_c;
  logic [XLEN+1:0]  div_diff_c;
  logic             div_ge_c;
  logic [XLEN-1:0]  div_rem_c, div_quo_c, div_res_c;
  logic [ACC_W-1:0] div_next_c;

  always_comb begin
    div_shift_c = {acc_q[ACC_W-1:XLEN], acc_q[XLEN-1]};
    div_diff_c  = {1'b0, div_shift_c} - {2'b00, opd_q};
    div_ge_c    = !div_diff_c[XLEN+1];
    div_rem_c   = div_ge_c ? div_diff_c[XLEN-1:0] : div_shift_c[XLEN-1:0];
    div_next_c  = {div_rem_c, acc_q[XLEN-2:0], div_ge_c};
    div_quo_c   = div_next_c[XLEN-1:0];
    if (sel_q) div_res_c = neg_q ? XLEN'(-div_rem_c) : div_rem_c;
    else       div_res_c = neg_q ? XLEN'(-div_quo_c) : div_quo_c;
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opd_d    = opd_q;
    neg_d    = neg_q;
    sel_d    = sel_q;
    result_d = result_q;

    if (mdFlush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ID_EX_mdValid) begin
            cnt_d = CNT_W'(XLEN - 1);
            if (ID_EX_mdOp[2]) begin
              opd_d = b_mag_c;
              acc_d = {{XLEN{1'b0}}, a_mag_c};
              sel_d = ID_EX_mdOp[1];
              // remainder follows the dividend sign; quotient the sign product
              neg_d = ID_EX_mdOp[1] ? a_neg_c : (a_neg_c ^ b_neg_c);
              if (div_zero_c || div_ovf_c) begin
                state_d  = ST_DONE;
                result_d = special_res_c;
              end else begin
                state_d = ST_DIV;
              end
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              result_d = fast_res_c;
`else
              opd_d   = a_mag_c;
              acc_d   = {{XLEN{1'b0}}, b_mag_c};
              sel_d   = (ID_EX_mdOp[1:0] != 2'b00);
              neg_d   = a_neg_c ^ b_neg_c;
              state_d = ST_MUL;
`endif
            end
          end
        end
`ifndef MULDIV_FAST_MUL_EN
        ST_MUL: begin
          acc_d = mul_next_c;
          if (cnt_q == '0) begin
            state_d  = ST_DONE;
            result_d = mul_res_c;
          end else begin
            cnt_d = CNT_W'(cnt_q - 1'b1);
          end
        end
`endif
        ST_DIV: begin
          acc_d = div_next_c;
          if (cnt_q == '0) begin
            state_d  = ST_DONE;
            result_d = div_res_c;
          end else begin
            cnt_d = CNT_W'(cnt_q - 1'b1);
          end
        end
        // retiring instruction still shows valid; never restart it here
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opd_q    <= '0;
      neg_q    <= 1'b0;
      sel_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      neg_q    <= neg_d;
      sel_q    <= sel_d;
      result_q <= result_d;
    end
  end

  // Hazard-unit handshake
  always_comb begin
    mdStall  = !rst && !mdFlush &&
               ((accept_c && !fast_hit_c) || (state_q == ST_MUL) || (state_q == ST_DIV));
    mdDone   = !rst && !mdFlush && ((state_q == ST_DONE) || fast_hit_c);
`ifdef MULDIV_FAST_MUL_EN
    mdResult = fast_hit_c ? fast_res_c : result_q;
`else
    mdResult = result_q;
`endif
  end

endmodule
